pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS core. Drives the enable and flush controls of the
//  IF/ID, ID/EX and EX/M pipeline registers and the PC, and inserts bubbles into M/WB.
//  Resolves three cases: load-use hazards, taken branches/jumps resolved in EX, and
//  variable-latency data-memory accesses issued from the EX/M stage.
//  Includes a memory-wait timeout with a sticky error flag and a saturating stall counter.
// PARAMETERS
//  MEM_TIMEOUT  255  consecutive MEM_WAIT cycles before ERROR (>=1)
//  CNT_W        16   width of stall_cnt
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous active-low reset
//  id_rs          in   5      rs field of the instruction in ID
//  id_rt          in   5      rt field of the instruction in ID
//  id_ex_rt       in   5      destination rt of the load in ID/EX
//  id_ex_memread  in   1      instruction in ID/EX is a load
//  ex_branch      in   1      branch or jump in EX resolved taken
//  ex_m_memread   in   1      EX/M holds a load
//  ex_m_memwrite  in   1      EX/M holds a store
//  mem_ready      in   1      data memory completes the current access this cycle
//  pc_en          out  1      PC update enable
//  if_id_en       out  1      IF/ID load enable
//  if_id_flush    out  1      IF/ID clear to NOP
//  id_ex_en       out  1      ID/EX load enable
//  id_ex_flush    out  1      ID/EX clear to bubble (all control bits 0)
//  ex_m_en        out  1      EX/M load enable
//  m_wb_bubble    out  1      M/WB loads a bubble (regwrite=0)
//  mem_req        out  1      data-memory access request
//  mem_timeout    out  1      sticky: memory never answered
//  stall_cnt      out  CNT_W  saturating count of cycles with pc_en=0
// BEHAVIOUR
//  Registered state is limited to the FSM state {RUN, MEM_WAIT, ERROR}, the timeout counter
//  (width $clog2(MEM_TIMEOUT+1)) and stall_cnt. All control outputs are combinational
//  decodes of the state and the inputs.
//  Reset (rst_n=0, takes effect immediately): state=RUN, timeout counter=0, stall_cnt=0.
//  Outputs while in reset: pc_en=if_id_en=id_ex_en=ex_m_en=1; flushes, m_wb_bubble,
//  mem_req and mem_timeout=0.
//  mem_access = ex_m_memread | ex_m_memwrite.
//  load_use = id_ex_memread & (id_ex_rt!=0) & (id_ex_rt==id_rs | id_ex_rt==id_rt).
//  RUN state, priority order:
//   1. mem_access & !mem_ready:
//      mem_req=1; all enables=0; m_wb_bubble=1; next state MEM_WAIT; timeout counter<=0.
//   2. ex_branch:
//      if_id_flush=1 and id_ex_flush=1; enables stay 1; load_use is ignored.
//   3. load_use:
//      pc_en=0, if_id_en=0, id_ex_flush=1 for exactly one cycle. The next cycle re-evaluates
//      with the bubble now in ID/EX, so load_use drops.
//   4. Otherwise all enables=1 and all flushes=0.
//   mem_req equals mem_access in every RUN case. A zero-wait access (mem_ready in the same
//   cycle) does not stall.
//  MEM_WAIT state:
//   - mem_req=1; pc_en, if_id_en, id_ex_en and ex_m_en=0; m_wb_bubble=1.
//   - ex_branch and load_use are ignored; the frozen stages re-present them after the wait.
//   - mem_ready=1: this cycle all enables=1 and m_wb_bubble=0, so EX/M advances.
//     Next state is RUN.
//   - Otherwise the timeout counter increments. When the counter equals MEM_TIMEOUT-1
//     and mem_ready=0, next state is ERROR. mem_ready wins over timeout in the same cycle.
//  ERROR state:
//   - All enables=0, mem_req=0, m_wb_bubble=1, mem_timeout=1.
//   - The state is held until rst_n is asserted.
//  stall_cnt: increments on every cycle with pc_en=0 in RUN or MEM_WAIT. It holds at
//  2^CNT_W-1 and is frozen in ERROR.
//  Flush outputs are never asserted in the same cycle as their register's enable being 0.
//  Reset asserted mid-MEM_WAIT: the request drops immediately and the state returns to RUN.
// TESTING
//  - Load-use: id_ex_memread=1, id_ex_rt=8, id_rs=8 -> one cycle with pc_en=0, if_id_en=0,
//    id_ex_flush=1; stall_cnt=1. Same stimulus with id_ex_rt=0 -> no stall.
//  - Branch + load-use in the same cycle: ex_branch=1 with a load_use match -> if_id_flush=1,
//    id_ex_flush=1, pc_en=1, stall_cnt unchanged.
//  - Memory wait: ex_m_memread=1, mem_ready low for 3 cycles then high -> mem_req high for
//    4 cycles; ex_m_en=0 for 3 cycles then 1; stall_cnt=3; state back to RUN.
//  - Timeout: MEM_TIMEOUT=4, mem_ready stuck at 0 -> ERROR entered after 1 RUN cycle plus
//    4 MEM_WAIT cycles; mem_timeout=1, mem_req=0, sticky until rst_n pulse.
//  - mem_ready rises exactly on cycle MEM_TIMEOUT-1 of MEM_WAIT -> returns to RUN,
//    mem_timeout stays 0.
//  - Reset mid-wait: rst_n=0 during MEM_WAIT -> mem_req=0 immediately, all enables=1,
//    stall_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the 5-stage pipeline datapath and its hazard sequencer.
// The datapath side (master) reports hazard sources and the memory handshake.
// The sequencer side (slave) returns the register enables, flushes and status.
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   // Hazard sources from the datapath
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic [4:0]       id_ex_rt;
   logic             id_ex_memread;
   logic             ex_branch;
   logic             ex_m_memread;
   logic             ex_m_memwrite;
   logic             mem_ready;

   // Pipeline controls and status back to the datapath
   logic             pc_en;
   logic             if_id_en;
   logic             if_id_flush;
   logic             id_ex_en;
   logic             id_ex_flush;
   logic             ex_m_en;
   logic             m_wb_bubble;
   logic             mem_req;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_rs, id_rt, id_ex_rt, id_ex_memread, ex_branch,
             ex_m_memread, ex_m_memwrite, mem_ready,
      input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
             ex_m_en, m_wb_bubble, mem_req, mem_timeout, stall_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_ex_rt, id_ex_memread, ex_branch,
             ex_m_memread, ex_m_memwrite, mem_ready,
      output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
             ex_m_en, m_wb_bubble, mem_req, mem_timeout, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core.
// Handles load-use stalls, taken branch/jump flushes and variable-latency data
// memory waits. A memory that never answers parks the core in a sticky ERROR state.
// stall_cnt counts cycles in which the PC was held, saturating at all-ones.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   pipe_hazard_ctrl_if.slave  bus
);

   localparam int                TO_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TO_W-1:0]   TO_LAST = TO_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERROR    = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic mem_access;
   logic load_use;

   logic pc_en;
   logic if_id_en;
   logic if_id_flush;
   logic id_ex_en;
   logic id_ex_flush;
   logic ex_m_en;
   logic m_wb_bubble;
   logic mem_req;
   logic mem_timeout;

   assign mem_access = bus.ex_m_memread | bus.ex_m_memwrite;

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign load_use = bus.id_ex_memread
                   & (bus.id_ex_rt != 5'd0)
                   & ((bus.id_ex_rt == bus.id_rs) | (bus.id_ex_rt == bus.id_rt));

   // Next-state, timeout counter and pipeline control decode.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
      state_d     = state_q;
      to_cnt_d    = to_cnt_q;
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      if_id_flush = 1'b0;
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b0;
      ex_m_en     = 1'b1;
      m_wb_bubble = 1'b0;
      mem_req     = 1'b0;
      mem_timeout = 1'b0;

      // While reset is held the defaults above apply, so a request drops at once.
      if (rst_n) begin
         unique case (state_q)
            ST_RUN: begin
               mem_req = mem_access;
               if (mem_access && !bus.mem_ready) begin
                  // Memory not done: freeze everything and bubble M/WB.
                  pc_en       = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_en    = 1'b0;
                  ex_m_en     = 1'b0;
                  m_wb_bubble = 1'b1;
                  to_cnt_d    = '0;
                  state_d     = ST_MEM_WAIT;
               end else if (bus.ex_branch) begin
                  // Wrong-path instructions in IF/ID and ID/EX are discarded;
                  // a load-use match on a discarded instruction is irrelevant.
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (load_use) begin
                  // Hold PC and IF/ID one cycle while a bubble enters ID/EX.
                  pc_en       = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end

            ST_MEM_WAIT: begin
               mem_req = 1'b1;
               if (bus.mem_ready) begin
                  // Access completes: let EX/M advance and resume.
                  state_d = ST_RUN;
               end else begin
                  pc_en       = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_en    = 1'b0;
                  ex_m_en     = 1'b0;
                  m_wb_bubble = 1'b1;
                  if (to_cnt_q == TO_LAST) begin
                     state_d = ST_ERROR;
                  end else begin
                     to_cnt_d = to_cnt_q + 1'b1;
                  end
               end
            end

            ST_ERROR: begin
               pc_en       = 1'b0;
               if_id_en    = 1'b0;
               id_ex_en    = 1'b0;
               ex_m_en     = 1'b0;
               m_wb_bubble = 1'b1;
               mem_timeout = 1'b1;
            end

            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   // Stall counter: count held-PC cycles, saturate, and freeze once in ERROR.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (state_q != ST_ERROR && !pc_en && stall_cnt_q != CNT_MAX) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // State, timeout counter and stall counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         to_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
         state_q     <= state_d;
         to_cnt_q    <= to_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.pc_en       = pc_en;
   assign bus.if_id_en    = if_id_en;
   assign bus.if_id_flush = if_id_flush;
   assign bus.id_ex_en    = id_ex_en;
   assign bus.id_ex_flush = id_ex_flush;
   assign bus.ex_m_en     = ex_m_en;
   assign bus.m_wb_bubble = m_wb_bubble;
   assign bus.mem_req     = mem_req;
   assign bus.mem_timeout = mem_timeout;
   assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// The driver applies one directed vector per cycle just after the rising edge and
// queues the hand-computed controls; the monitor pops and compares on the falling edge.
module tb_pipe_hazard_ctrl;

   localparam int MT = 4;
   localparam int CW = 4;

   // Control vector order:
   // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_m_en, m_wb_bubble, mem_req, mem_timeout}
   localparam logic [8:0] C_NORM  = 9'b1_1_0_1_0_1_0_0_0;
   localparam logic [8:0] C_MEMOK = 9'b1_1_0_1_0_1_0_1_0;
   localparam logic [8:0] C_LDUSE = 9'b0_0_0_1_1_1_0_0_0;
   localparam logic [8:0] C_BRAN  = 9'b1_1_1_1_1_1_0_0_0;
   localparam logic [8:0] C_STALL = 9'b0_0_0_0_0_0_1_1_0;
   localparam logic [8:0] C_ERR   = 9'b0_0_0_0_0_0_1_0_1;

   typedef struct {
      string          name;
      logic [8:0]     ctl;
      logic [CW-1:0]  cnt;
   } exp_t;

   logic clk;
   logic rst_n;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

   pipe_hazard_ctrl #(
      .MEM_TIMEOUT (MT),
      .CNT_W       (CW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one vector for the coming cycle and queue its expected response.
   task automatic drive(input string nm, input logic rst,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] exrt,
                        input logic exmr, input logic br, input logic mr, input logic mw,
                        input logic rdy, input logic [8:0] ectl, input int ecnt);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n             = rst;
      bus.id_rs         = rs;
      bus.id_rt         = rt;
      bus.id_ex_rt      = exrt;
      bus.id_ex_memread = exmr;
      bus.ex_branch     = br;
      bus.ex_m_memread  = mr;
      bus.ex_m_memwrite = mw;
      bus.mem_ready     = rdy;
      e.name = nm;
      e.ctl  = ectl;
      e.cnt  = CW'(ecnt);
      sb.push_back(e);
   endtask

   task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: ctl got %b want %b", nm, act, exp);
      end
   endtask

   task automatic check_cnt(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: stall_cnt got %0d want %0d", nm, act, exp);
      end
   endtask

   // Monitor: compare DUT outputs against the oldest queued expectation.
   initial begin
      exp_t       e;
      logic [8:0] act;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en, bus.id_ex_flush,
                   bus.ex_m_en, bus.m_wb_bubble, bus.mem_req, bus.mem_timeout};
            check(e.name, act, e.ctl);
            check_cnt(e.name, bus.stall_cnt, e.cnt);
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus.
   initial begin
      rst_n             = 1'b0;
      bus.id_rs         = '0;
      bus.id_rt         = '0;
      bus.id_ex_rt      = '0;
      bus.id_ex_memread = 1'b0;
      bus.ex_branch     = 1'b0;
      bus.ex_m_memread  = 1'b0;
      bus.ex_m_memwrite = 1'b0;
      bus.mem_ready     = 1'b0;

      //    name            rst  rs  rt exrt exmr br mr mw rdy  ctl      cnt
      // Reset forces pass-through controls even with hazards present.
      drive("reset_out",    0,   8,  0,  8,   1,  1, 1, 0, 0,  C_NORM,  0);
      drive("idle",         1,   0,  0,  0,   0,  0, 0, 0, 0,  C_NORM,  0);

      // Load-use via rs, then the bubble clears it.
      drive("lduse_rs",     1,   8,  0,  8,   1,  0, 0, 0, 0,  C_LDUSE, 0);
      drive("lduse_after",  1,   0,  0,  0,   0,  0, 0, 0, 0,  C_NORM,  1);
      // Destination register 0 never stalls.
      drive("lduse_r0",     1,   0,  0,  0,   1,  0, 0, 0, 0,  C_NORM,  1);
      // Load-use via rt.
      drive("lduse_rt",     1,   3,  5,  5,   1,  0, 0, 0, 0,  C_LDUSE, 1);
      // Branch beats load-use: flush, no stall.
      drive("branch_lduse", 1,   8,  0,  8,   1,  1, 0, 0, 0,  C_BRAN,  2);
      drive("after_branch", 1,   0,  0,  0,   0,  0, 0, 0, 0,  C_NORM,  2);
      // Zero-wait store does not stall.
      drive("store_0wait",  1,   0,  0,  0,   0,  0, 0, 1, 1,  C_MEMOK, 2);

      // Memory wait of 3 cycles; branch/load-use present but ignored.
      drive("mw_run",       1,   8,  0,  8,   1,  1, 1, 0, 0,  C_STALL, 2);
      drive("mw_wait1",     1,   8,  0,  8,   1,  1, 1, 0, 0,  C_STALL, 3);
      drive("mw_wait2",     1,   0,  0,  0,   0,  0, 1, 0, 0,  C_STALL, 4);
      drive("mw_ready",     1,   0,  0,  0,   0,  0, 1, 0, 1,  C_MEMOK, 5);
      drive("mw_back_run",  1,   0,  0,  0,   0,  0, 0, 0, 0,  C_NORM,  5);

      // Ready arrives on the last wait cycle before timeout.
      drive("edge_run",     1,   0,  0,  0,   0,  0, 1, 0, 0,  C_STALL, 5);
      drive("edge_w0",      1,   0,  0,  0,   0,  0, 1, 0, 0,  C_STALL, 6);
      drive("edge_w1",      1,   0,  0,  0,   0,  0, 1, 0, 0,  C_STALL, 7);
      drive("edge_w2",      1,   0,  0,  0,   0,  0, 1, 0, 0,  C_STALL, 8);
      drive("edge_w3_rdy",  1,   0,  0,  0,   0,  0, 1, 0, 1,  C_MEMOK, 9);
      drive("edge_run2",    1,   0,  0,  0,   0,  0, 0, 0, 0,  C_NORM,  9);

      // Reset asserted mid-wait.
      drive("rmw_run",      1,   0,  0,  0,   0,  0, 1, 0, 0,  C_STALL, 9);
      drive("rmw_wait",     1,   0,  0,  0,   0,  0, 1, 0, 0,  C_STALL, 10);
      drive("rmw_reset",    0,   0,  0,  0,   0,  0, 1, 0, 0,  C_NORM,  0);
      drive("rmw_release",  1,   0,  0,  0,   0,  0, 0, 0, 0,  C_NORM,  0);

      // Timeout: 1 RUN cycle + MT wait cycles, then sticky ERROR.
      drive("to_run",       1,   0,  0,  0,   0,  0, 1, 0, 0,  C_STALL, 0);
      drive("to_w0",        1,   0,  0,  0,   0,  0, 1, 0, 0,  C_STALL, 1);
      drive("to_w1",        1,   0,  0,  0,   0,  0, 1, 0, 0,  C_STALL, 2);
      drive("to_w2",        1,   0,  0,  0,   0,  0, 1, 0, 0,  C_STALL, 3);
      drive("to_w3",        1,   0,  0,  0,   0,  0, 1, 0, 0,  C_STALL, 4);
      drive("to_error",     1,   0,  0,  0,   0,  0, 1, 0, 0,  C_ERR,   5);
      drive("to_err_rdy",   1,   0,  0,  0,   0,  0, 1, 0, 1,  C_ERR,   5);
      drive("to_err_idle",  1,   8,  0,  8,   1,  1, 0, 0, 0,  C_ERR,   5);
      drive("to_reset",     0,   0,  0,  0,   0,  0, 0, 0, 0,  C_NORM,  0);
      drive("to_release",   1,   0,  0,  0,   0,  0, 0, 0, 0,  C_NORM,  0);

      // Saturation: hold a load-use hazard long enough to pin the counter.
      for (int i = 0; i < 18; i++) begin
         drive("sat_lduse", 1, 8, 0, 8, 1, 0, 0, 0, 0, C_LDUSE, (i > 15) ? 15 : i);
      end
      drive("sat_hold",     1,   0,  0,  0,   0,  0, 0, 0, 0,  C_NORM,  15);

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left want 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
